// File: rtl/prog_sequencer.sv
// Fetch sequencer for the 9-bit CPU: launches one of three resident programs,
// steps PC, resolves BEQ/BNE, detects HALT and guards each run with range and watchdog checks.
module prog_sequencer #(
    parameter int PROD_BASE  = 0,
    parameter int PROD_END   = 29,
    parameter int STRM_BASE  = 30,
    parameter int STRM_END   = 41,
    parameter int PAIR_BASE  = 42,
    parameter int PAIR_END   = 73,
    parameter int MAX_CYCLES = 4096,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       prog_sel,
    input  logic [8:0]       inst,
    input  logic             zero_flag,
    output logic [7:0]       PC,
    output logic             run,
    output logic             done,
    output logic             fault,
    output logic [1:0]       active_prog,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [8:0]       HALT_INST = 9'h1FF;
    localparam logic [3:0]       OP_BEQ    = 4'b1011;
    localparam logic [3:0]       OP_BNE    = 4'b1000;
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           r_state;
    logic [7:0]       r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fault;
    logic [1:0]       r_active;
    logic             r_start_q;

    state_t           w_state_nxt;
    logic [7:0]       w_pc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_fault_nxt;
    logic [1:0]       w_active_nxt;

    logic             w_launch_ev;
    logic [3:0]       w_op;
    logic             w_taken;
    logic [7:0]       w_offset;
    logic [7:0]       w_nxt;
    logic [7:0]       w_base;
    logic [7:0]       w_end;
    logic             w_out_of_range;
    logic [CNT_W-1:0] w_cnt_inc;

    // Address window of the program currently owning the fetch stream.
    always_comb begin
        w_base = 8'(PAIR_BASE);
        w_end  = 8'(PAIR_END);
        case (r_active)
            2'd0: begin
                w_base = 8'(PROD_BASE);
                w_end  = 8'(PROD_END);
            end
            2'd1: begin
                w_base = 8'(STRM_BASE);
                w_end  = 8'(STRM_END);
            end
            default: begin
                w_base = 8'(PAIR_BASE);
                w_end  = 8'(PAIR_END);
            end
        endcase
    end

    always_comb begin
        w_launch_ev    = start & ~r_start_q;
        w_op           = inst[8:5];
        w_taken        = ((w_op == OP_BEQ) & zero_flag) | ((w_op == OP_BNE) & ~zero_flag);
        w_offset       = {{3{inst[4]}}, inst[4:0]};
        w_nxt          = w_taken ? (r_pc + w_offset) : (r_pc + 8'd1);
        w_out_of_range = (w_nxt < w_base) || (w_nxt > w_end);
        w_cnt_inc      = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + 1'b1);
    end

    // Next-state logic; PC is held whenever the run ends.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_cnt_nxt    = r_cnt;
        w_fault_nxt  = r_fault;
        w_active_nxt = r_active;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_launch_ev) begin
                    w_active_nxt = prog_sel;
                    if (prog_sel == 2'd3) begin
                        w_state_nxt = S_DONE;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                w_pc_nxt    = w_base;
                w_cnt_nxt   = '0;
                w_fault_nxt = 1'b0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_cnt_nxt = w_cnt_inc;
                if (inst == HALT_INST) begin
                    w_state_nxt = S_DONE;
                    w_fault_nxt = 1'b0;
                end else if (w_out_of_range || (r_cnt == WD_LAST)) begin
                    w_state_nxt = S_DONE;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_pc_nxt = w_nxt;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= 8'd0;
            r_cnt     <= '0;
            r_fault   <= 1'b0;
            r_active  <= 2'd0;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_fault   <= w_fault_nxt;
            r_active  <= w_active_nxt;
            r_start_q <= start;
        end
    end

    assign PC          = r_pc;
    assign run         = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign fault       = r_fault;
    assign active_prog = r_active;
    assign cycle_cnt   = r_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed programs plus random ROM images, checked
// against a program interpreter; a second instance with an 8-cycle watchdog runs in lockstep.
module tb_prog_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  prog_sel;

  logic [8:0]  rom_mem [256];
  logic        zf_mem  [256];

  logic [8:0]  inst_m, inst_w;
  logic        zf_m, zf_w;
  logic [7:0]  pc_m, pc_w;
  logic        run_m, run_w, done_m, done_w, fault_m, fault_w;
  logic [1:0]  act_m, act_w, dbg_m, dbg_w;
  logic [15:0] cnt_m, cnt_w;

  logic [7:0]  exp_q[$];
  int          n_cmp;
  int          n_err;
  int          bases[3] = '{0, 30, 42};
  int          ends[3]  = '{29, 41, 73};

  assign inst_m = rom_mem[pc_m];
  assign zf_m   = zf_mem[pc_m];
  assign inst_w = rom_mem[pc_w];
  assign zf_w   = zf_mem[pc_w];

  prog_sequencer dut (
    .CLK(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
    .inst(inst_m), .zero_flag(zf_m), .PC(pc_m), .run(run_m), .done(done_m),
    .fault(fault_m), .active_prog(act_m), .cycle_cnt(cnt_m), .o_dbg_state(dbg_m)
  );

  prog_sequencer #(.MAX_CYCLES(8)) dut_wd (
    .CLK(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
    .inst(inst_w), .zero_flag(zf_w), .PC(pc_w), .run(run_w), .done(done_w),
    .fault(fault_w), .active_prog(act_w), .cycle_cnt(cnt_w), .o_dbg_state(dbg_w)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: interpret the program from its base address using the ROM and per-PC flags.
  task automatic model_run(input int sel, input int maxc, input bit fill,
                           output int fpc, output bit ffault, output int fcnt);
    int pc, nxt, off, lo, hi, cnt;
    logic [8:0] w;
    bit fin;
    lo = bases[sel];
    hi = ends[sel];
    pc = lo;
    cnt = 0;
    fin = 0;
    ffault = 0;
    if (fill) exp_q.delete();
    while (!fin) begin
      if (fill) exp_q.push_back(pc[7:0]);
      w = rom_mem[pc];
      cnt++;
      if (w == 9'h1FF) begin
        ffault = 0;
        fin = 1;
      end else begin
        off = w[4] ? (int'(w[4:0]) - 32) : int'(w[4:0]);
        if ((w[8:5] == 4'hB && zf_mem[pc]) || (w[8:5] == 4'h8 && !zf_mem[pc]))
          nxt = (pc + off) & 255;
        else
          nxt = (pc + 1) & 255;
        if (nxt < lo || nxt > hi || cnt == maxc) begin
          ffault = 1;
          fin = 1;
        end else begin
          pc = nxt;
        end
      end
    end
    fpc = pc;
    fcnt = cnt;
  endtask

  // driver: clean start edge, then follow the run cycle by cycle
  task automatic do_launch(input int sel);
    int fpc, fcnt, wpc, wcnt, n, guard;
    bit ffault, wfault;
    start = 1'b0;
    tick();
    prog_sel = 2'(sel);
    start = 1'b1;
    if (sel == 3) begin
      tick();
      check("bad_sel_done", 32'(done_m), 1);
      check("bad_sel_fault", 32'(fault_m), 1);
      check("bad_sel_active", 32'(act_m), 3);
      check("bad_sel_run", 32'(run_m), 0);
      check("bad_sel_wd_fault", 32'(fault_w), 1);
      return;
    end
    model_run(sel, 4096, 1'b1, fpc, ffault, fcnt);
    model_run(sel, 8, 1'b0, wpc, wfault, wcnt);
    n = exp_q.size();
    tick();
    check("launch_run", 32'(run_m), 0);
    for (int k = 0; k < n; k++) begin
      tick();
      check("run_level", 32'(run_m), 1);
      check("run_pc", 32'(pc_m), 32'(exp_q[k]));
      check("run_cnt", 32'(cnt_m), 32'(k));
    end
    tick();
    check("end_done", 32'(done_m), 1);
    check("end_fault", 32'(fault_m), 32'(ffault));
    check("end_pc", 32'(pc_m), 32'(fpc));
    check("end_cnt", 32'(cnt_m), 32'(fcnt));
    check("end_active", 32'(act_m), 32'(sel));
    guard = 0;
    while (!done_w && guard < 12) begin
      tick();
      guard++;
    end
    check("wd_done", 32'(done_w), 1);
    check("wd_fault", 32'(fault_w), 32'(wfault));
    check("wd_pc", 32'(pc_w), 32'(wpc));
    check("wd_cnt", 32'(cnt_w), 32'(wcnt));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) begin
      rom_mem[i] = 9'h000;
      zf_mem[i] = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, 32'(pc_m), 0);
    check({tag, "_run"}, 32'(run_m), 0);
    check({tag, "_done"}, 32'(done_m), 0);
    check({tag, "_fault"}, 32'(fault_m), 0);
    check({tag, "_cnt"}, 32'(cnt_m), 0);
    check({tag, "_active"}, 32'(act_m), 0);
    check({tag, "_wd_run"}, 32'(run_w), 0);
  endtask

  logic [3:0] ops[6] = '{4'h0, 4'h1, 4'h3, 4'h5, 4'h9, 4'hE};

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    prog_sel = 2'd0;
    clear_rom();
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("reset");

    // straight-line STRING MATCH ending in HALT
    for (int i = 0; i < 256; i++) zf_mem[i] = 1'b1;
    rom_mem[41] = 9'h1FF;
    do_launch(1);
    for (int i = 0; i < 5; i++) tick();
    check("held_start_done", 32'(done_m), 1);
    check("held_start_pc", 32'(pc_m), 41);
    check("held_start_cnt", 32'(cnt_m), 12);
    do_launch(1);

    // BNE back by 4 at PC=5: taken loops until the watchdog, not-taken falls through
    clear_rom();
    rom_mem[5] = 9'h11C;
    do_launch(0);
    for (int i = 0; i < 256; i++) zf_mem[i] = 1'b1;
    do_launch(0);

    // BEQ +15 at PC=70 leaves the CLOSEST PAIR window
    clear_rom();
    for (int i = 0; i < 256; i++) zf_mem[i] = 1'b1;
    rom_mem[70] = 9'h16F;
    do_launch(2);

    // start edge during RUN is ignored; reset mid-run returns to IDLE
    clear_rom();
    rom_mem[5] = 9'h11C;
    start = 1'b0;
    tick();
    prog_sel = 2'd0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("relaunch_ignored_run", 32'(run_m), 1);
    tick();
    check("relaunch_ignored_run2", 32'(run_m), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check_reset_state("midrun_reset");

    do_launch(3);

    // random ROM images and flags
    for (int t = 0; t < 10; t++) begin
      clear_rom();
      for (int i = 0; i < 74; i++) begin
        int r;
        r = int'($urandom_range(0, 15));
        zf_mem[i] = 1'($urandom_range(0, 1));
        if (r < 2) rom_mem[i] = 9'h1FF;
        else if (r < 5) rom_mem[i] = {4'hB, 5'($urandom_range(0, 31))};
        else if (r < 8) rom_mem[i] = {4'h8, 5'($urandom_range(0, 31))};
        else rom_mem[i] = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 31))};
      end
      do_launch(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
